// File: rtl/conv_arb_pkg.sv
// ---------------------------------------------------------------------------
// conv_arb_pkg
//   Shared definitions for the conv read-path arbiter and its helpers:
//   FSM state encoding and master index constants.
// ---------------------------------------------------------------------------
package conv_arb_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        ADDR = S_ADDR,
        DATA = S_DATA
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/burst_beat_counter.sv
// ---------------------------------------------------------------------------
// burst_beat_counter
//   Remaining-beat counter for one burst. Loaded with the burst length on the
//   address handshake and decremented on every response handshake.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     load     : capture len as the remaining beat count
//     len      : burst length in beats
//     dec      : one response beat transferred
//     last     : the beat transferred this cycle is the final one
// ---------------------------------------------------------------------------
module burst_beat_counter #(
    parameter int LENW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [LENW-1:0] len,
    input  logic            dec,
    output logic            last
);

    logic [LENW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= len;
        end else if (dec && (count != '0)) begin
            count <= count - LENW'(1);
        end
    end

    assign last = (count == LENW'(1)) && dec;

endmodule

// File: rtl/conv_rd_arbiter.sv
// ---------------------------------------------------------------------------
// conv_rd_arbiter
//   Two-master / one-slave read arbiter. One burst outstanding at a time; the
//   grant is locked from the address handshake until the last response beat.
//   Round-robin between masters when both request in the same cycle.
//
//   Handshake rule for every channel: a transfer happens on a rising clk edge
//   where valid and ready are both 1; valid never waits on ready.
//
//   Ports:
//     clk, rst                   : clock, asynchronous active-high reset
//     m0_* / m1_*                : master-side address and response channels
//     req_read_addr/_valid/_ready/_len : memory-side address channel
//     resp_read_data/_valid/_ready     : memory-side response channel
//     stat_bursts_m0/_m1         : completed-burst counters (ARB_STATS_EN only)
//     fsm_state                  : current FSM state, for observation
//
//   Optional feature macro: ARB_STATS_EN (adds the stat_bursts_* counters).
// ---------------------------------------------------------------------------
module conv_rd_arbiter
    import conv_arb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int LENW   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [AWIDTH-1:0] m0_req_read_addr,
    input  logic              m0_req_read_addr_valid,
    output logic              m0_req_read_addr_ready,
    input  logic [LENW-1:0]   m0_req_read_len,
    output logic [DWIDTH-1:0] m0_resp_read_data,
    output logic              m0_resp_read_data_valid,
    input  logic              m0_resp_read_data_ready,

    input  logic [AWIDTH-1:0] m1_req_read_addr,
    input  logic              m1_req_read_addr_valid,
    output logic              m1_req_read_addr_ready,
    input  logic [LENW-1:0]   m1_req_read_len,
    output logic [DWIDTH-1:0] m1_resp_read_data,
    output logic              m1_resp_read_data_valid,
    input  logic              m1_resp_read_data_ready,

    output logic [AWIDTH-1:0] req_read_addr,
    output logic              req_read_addr_valid,
    input  logic              req_read_addr_ready,
    output logic [LENW-1:0]   req_read_len,
    input  logic [DWIDTH-1:0] resp_read_data,
    input  logic              resp_read_data_valid,
    output logic              resp_read_data_ready,

`ifdef ARB_STATS_EN
    output logic [31:0]       stat_bursts_m0,
    output logic [31:0]       stat_bursts_m1,
`endif

    output logic [1:0]        fsm_state
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_ptr_q, rr_ptr_d;

    logic              g_addr_valid;
    logic [AWIDTH-1:0] g_addr;
    logic [LENW-1:0]   g_len;
    logic              g_resp_ready;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_last;
    logic burst_done;

    // Granted master's request/response-ready, selected by the locked grant.
    assign g_addr_valid = (grant_q == M1) ? m1_req_read_addr_valid  : m0_req_read_addr_valid;
    assign g_addr       = (grant_q == M1) ? m1_req_read_addr        : m0_req_read_addr;
    assign g_len        = (grant_q == M1) ? m1_req_read_len         : m0_req_read_len;
    assign g_resp_ready = (grant_q == M1) ? m1_resp_read_data_ready : m0_resp_read_data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= M0;
            rr_ptr_q <= M0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        burst_done = 1'b0;

        req_read_addr           = '0;
        req_read_addr_valid     = 1'b0;
        req_read_len            = '0;
        resp_read_data_ready    = 1'b0;
        m0_req_read_addr_ready  = 1'b0;
        m1_req_read_addr_ready  = 1'b0;
        m0_resp_read_data       = '0;
        m0_resp_read_data_valid = 1'b0;
        m1_resp_read_data       = '0;
        m1_resp_read_data_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // Arbitration is registered: nothing is forwarded here.
                if (m0_req_read_addr_valid && m1_req_read_addr_valid) begin
                    grant_d = rr_ptr_q;
                    state_d = ADDR;
                end else if (m1_req_read_addr_valid) begin
                    grant_d = M1;
                    state_d = ADDR;
                end else if (m0_req_read_addr_valid) begin
                    grant_d = M0;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                req_read_addr       = g_addr;
                req_read_addr_valid = g_addr_valid;
                req_read_len        = g_len;
                if (grant_q == M1) begin
                    m1_req_read_addr_ready = req_read_addr_ready;
                end else begin
                    m0_req_read_addr_ready = req_read_addr_ready;
                end

                if (!g_addr_valid) begin
                    // Master withdrew before the handshake: drop it silently.
                    state_d = IDLE;
                end else if (req_read_addr_ready) begin
                    if (g_len == '0) begin
                        // Zero-length burst completes on the address beat.
                        state_d    = IDLE;
                        rr_ptr_d   = ~rr_ptr_q;
                        burst_done = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = DATA;
                    end
                end
            end

            DATA: begin
                resp_read_data_ready = g_resp_ready;
                if (grant_q == M1) begin
                    m1_resp_read_data       = resp_read_data;
                    m1_resp_read_data_valid = resp_read_data_valid;
                end else begin
                    m0_resp_read_data       = resp_read_data;
                    m0_resp_read_data_valid = resp_read_data_valid;
                end

                cnt_dec = resp_read_data_valid && g_resp_ready;
                if (cnt_last) begin
                    state_d    = IDLE;
                    rr_ptr_d   = ~grant_q;
                    burst_done = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    burst_beat_counter #(
        .LENW (LENW)
    ) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .len  (g_len),
        .dec  (cnt_dec),
        .last (cnt_last)
    );

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts_m0 <= '0;
            stat_bursts_m1 <= '0;
        end else if (burst_done) begin
            if (grant_q == M1) begin
                stat_bursts_m1 <= stat_bursts_m1 + 32'd1;
            end else begin
                stat_bursts_m0 <= stat_bursts_m0 + 32'd1;
            end
        end
    end
`else
    logic unused_done;
    assign unused_done = burst_done;
`endif

    assign fsm_state = state_q;

endmodule

// File: tb/tb_conv_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_conv_rd_arbiter
//   Directed scenarios for conv_rd_arbiter: single master, contention,
//   response backpressure, withdrawn request, zero-length burst and
//   asynchronous reset mid-burst. Expected address beats and per-master data
//   beats are queued by the drivers and consumed by an edge-sampling monitor.
// ---------------------------------------------------------------------------
module tb_conv_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_addr_valid, m1_addr_valid;
    logic          m0_addr_ready, m1_addr_ready;
    logic [LW-1:0] m0_len, m1_len;
    logic [DW-1:0] m0_data, m1_data;
    logic          m0_data_valid, m1_data_valid;
    logic          m0_data_ready, m1_data_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_addr_valid;
    logic          mem_addr_ready;
    logic [LW-1:0] mem_len;
    logic [DW-1:0] mem_data;
    logic          mem_data_valid;
    logic          mem_data_ready;
    logic [1:0]    fsm_state;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_m0, stat_m1;
`endif

    logic [AW+LW-1:0] exp_addr_q[$];
    logic [DW-1:0]    exp_q0[$];
    logic [DW-1:0]    exp_q1[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int beats0    = 0;
    int beats1    = 0;

    conv_rd_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LENW(LW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .m0_req_read_addr        (m0_addr),
        .m0_req_read_addr_valid  (m0_addr_valid),
        .m0_req_read_addr_ready  (m0_addr_ready),
        .m0_req_read_len         (m0_len),
        .m0_resp_read_data       (m0_data),
        .m0_resp_read_data_valid (m0_data_valid),
        .m0_resp_read_data_ready (m0_data_ready),
        .m1_req_read_addr        (m1_addr),
        .m1_req_read_addr_valid  (m1_addr_valid),
        .m1_req_read_addr_ready  (m1_addr_ready),
        .m1_req_read_len         (m1_len),
        .m1_resp_read_data       (m1_data),
        .m1_resp_read_data_valid (m1_data_valid),
        .m1_resp_read_data_ready (m1_data_ready),
        .req_read_addr           (mem_addr),
        .req_read_addr_valid     (mem_addr_valid),
        .req_read_addr_ready     (mem_addr_ready),
        .req_read_len            (mem_len),
        .resp_read_data          (mem_data),
        .resp_read_data_valid    (mem_data_valid),
        .resp_read_data_ready    (mem_data_ready),
`ifdef ARB_STATS_EN
        .stat_bursts_m0          (stat_m0),
        .stat_bursts_m1          (stat_m1),
`endif
        .fsm_state               (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic fail_now(input string name, input logic [63:0] got);
        total_cnt++;
        $display("FAIL %s: got %0h expected nothing", name, got);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mem_addr_valid && mem_addr_ready) begin
            if (exp_addr_q.size() == 0) fail_now("addr_unexpected", {mem_addr, mem_len});
            else check("addr_order", {mem_addr, mem_len}, exp_addr_q.pop_front());
        end
        if (m0_data_valid && m0_data_ready) begin
            beats0++;
            if (exp_q0.size() == 0) fail_now("m0_beat_unexpected", m0_data);
            else check("m0_beat", m0_data, exp_q0.pop_front());
        end
        if (m1_data_valid && m1_data_ready) begin
            beats1++;
            if (exp_q1.size() == 0) fail_now("m1_beat_unexpected", m1_data);
            else check("m1_beat", m1_data, exp_q1.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_defaults();
        m0_addr = 32'hAAAA_0000; m0_addr_valid = 1'b0; m0_len = 32'd7; m0_data_ready = 1'b1;
        m1_addr = 32'hBBBB_0000; m1_addr_valid = 1'b0; m1_len = 32'd7; m1_data_ready = 1'b1;
        mem_addr_ready = 1'b1;
        mem_data       = 32'hA5A5_A5A5;
        mem_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_defaults();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic exp_addr(input logic [AW-1:0] a, input logic [LW-1:0] l);
        exp_addr_q.push_back({a, l});
    endtask

    // Waits for one memory-side address handshake; returns just after the edge.
    task automatic wait_addr(input string name);
        bit done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = mem_addr_valid && mem_addr_ready;
            @(posedge clk); #1;
        end
        if (!done) fail_now({name, "_addr_timeout"}, 64'(fsm_state));
    endtask

    // Memory returns n beats base, base+1, ... to granted master g. With bp set,
    // the granted master's response ready toggles 1,0,1,0...
    task automatic mem_beats(input int g, input int n, input logic [DW-1:0] base, input bit bp);
        int  sent = 0;
        int  cyc  = 0;
        bit  tog  = 1'b1;
        bit  fire;
        mem_data_valid = 1'b1;
        mem_data       = base;
        if (g == 0) exp_q0.push_back(base); else exp_q1.push_back(base);
        while (sent < n && cyc < 200) begin
            if (bp) begin
                if (g == 0) m0_data_ready = tog; else m1_data_ready = tog;
                tog = ~tog;
            end
            @(negedge clk);
            check("resp_ready_mirror", 64'(mem_data_ready),
                  64'((g == 0) ? m0_data_ready : m1_data_ready));
            check("other_resp_valid", 64'((g == 0) ? m1_data_valid : m0_data_valid), 64'd0);
            check("grant_held_data", 64'(fsm_state), 64'd2);
            fire = mem_data_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                sent++;
                if (sent < n) begin
                    mem_data = base + DW'(sent);
                    if (g == 0) exp_q0.push_back(mem_data); else exp_q1.push_back(mem_data);
                end
            end
        end
        mem_data_valid = 1'b0;
        m0_data_ready  = 1'b1;
        m1_data_ready  = 1'b1;
        if (sent < n) fail_now("beats_timeout", 64'(sent));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int b0, b1;
        rst = 1'b1;
        drive_defaults();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_state", 64'(fsm_state), 64'd0);
        check("rst_addr_valid", 64'(mem_addr_valid), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_len", 64'(mem_len), 64'd0);
        check("rst_resp_ready", 64'(mem_data_ready), 64'd0);
        check("rst_m_addr_ready", 64'({m0_addr_ready, m1_addr_ready}), 64'd0);
        check("rst_m_resp_valid", 64'({m0_data_valid, m1_data_valid}), 64'd0);
        check("rst_m_data", {m0_data, m1_data}, 64'd0);
`ifdef ARB_STATS_EN
        check("rst_stats", {stat_m0, stat_m1}, 64'd0);
`endif

        // Single master, len 9
        @(posedge clk); #1;
        m0_addr = 32'h100; m0_len = 32'd9; m0_addr_valid = 1'b1;
        exp_addr(32'h100, 32'd9);
        #1 check("single_no_fwd_idle", 64'(mem_addr_valid), 64'd0);
        @(posedge clk); #1;
        check("single_addr_valid_c2", 64'(mem_addr_valid), 64'd1);
        check("single_addr", 64'(mem_addr), 64'h100);
        wait_addr("single");
        m0_addr_valid = 1'b0;
        b1 = beats1;
        mem_beats(0, 9, 32'd1, 1'b0);
        check("single_idle_after", 64'(fsm_state), 64'd0);
        check("single_m1_no_beats", 64'(beats1 - b1), 64'd0);

        // Contention, 4 bursts of len 3
        do_reset();
        b0 = beats0; b1 = beats1;
        m0_addr = 32'h1000; m0_len = 32'd3;
        m1_addr = 32'h2000; m1_len = 32'd3;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_addr(32'h1000, 32'd3); else exp_addr(32'h2000, 32'd3);
        end
        m0_addr_valid = 1'b1; m1_addr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_addr("contend");
            mem_beats(i % 2, 3, 32'h100 * (i + 1), 1'b0);
        end
        m0_addr_valid = 1'b0; m1_addr_valid = 1'b0;
        check("contend_m0_beats", 64'(beats0 - b0), 64'd6);
        check("contend_m1_beats", 64'(beats1 - b1), 64'd6);

        // Backpressure: m1 len 4, ready toggling
        do_reset();
        m1_addr = 32'h300; m1_len = 32'd4; m1_addr_valid = 1'b1;
        exp_addr(32'h300, 32'd4);
        wait_addr("bp");
        m1_addr_valid = 1'b0;
        b1 = beats1;
        mem_beats(1, 4, 32'h30, 1'b1);
        check("bp_m1_beats", 64'(beats1 - b1), 64'd4);
        check("bp_idle_after", 64'(fsm_state), 64'd0);

        // Withdrawn request
        do_reset();
        mem_addr_ready = 1'b0;
        m0_addr = 32'h400; m0_len = 32'd1; m0_addr_valid = 1'b1;
        @(posedge clk); #1;
        check("wd_state_addr", 64'(fsm_state), 64'd1);
        check("wd_addr_valid", 64'(mem_addr_valid), 64'd1);
        m0_addr_valid = 1'b0;
        #1 check("wd_addr_valid_drop", 64'(mem_addr_valid), 64'd0);
        @(posedge clk); #1;
        check("wd_state_idle", 64'(fsm_state), 64'd0);
`ifdef ARB_STATS_EN
        check("wd_stat_m0", 64'(stat_m0), 64'd0);
`endif
        mem_addr_ready = 1'b1;
        m0_addr = 32'h410; m0_len = 32'd1;
        m1_addr = 32'h420; m1_len = 32'd2;
        exp_addr(32'h410, 32'd1);
        exp_addr(32'h420, 32'd2);
        m0_addr_valid = 1'b1; m1_addr_valid = 1'b1;
        wait_addr("wd_m0");
        m0_addr_valid = 1'b0;
        mem_beats(0, 1, 32'h41, 1'b0);
        wait_addr("wd_m1");
        m1_addr_valid = 1'b0;
        mem_beats(1, 2, 32'h42, 1'b0);

        // Zero length burst from m0
        do_reset();
        m0_addr = 32'h500; m0_len = 32'd0; m0_addr_valid = 1'b1;
        exp_addr(32'h500, 32'd0);
        wait_addr("zl");
        m0_addr_valid = 1'b0;
        check("zl_idle", 64'(fsm_state), 64'd0);
`ifdef ARB_STATS_EN
        check("zl_stat_m0", 64'(stat_m0), 64'd1);
`endif
        mem_data_valid = 1'b1; mem_data = 32'hDEAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("zl_stray_ready", 64'(mem_data_ready), 64'd0);
            @(posedge clk); #1;
        end
        mem_data_valid = 1'b0;
        m0_addr = 32'h510; m0_len = 32'd0;
        m1_addr = 32'h520; m1_len = 32'd0;
        exp_addr(32'h520, 32'd0);
        exp_addr(32'h510, 32'd0);
        m0_addr_valid = 1'b1; m1_addr_valid = 1'b1;
        wait_addr("zl_m1");
        m1_addr_valid = 1'b0;
        wait_addr("zl_m0");
        m0_addr_valid = 1'b0;
`ifdef ARB_STATS_EN
        check("zl_stats_end", {stat_m0, stat_m1}, {32'd2, 32'd1});
`endif

        // Async reset mid-burst: m0 len 5, reset after beat 2
        do_reset();
        m0_addr = 32'h600; m0_len = 32'd5; m0_addr_valid = 1'b1;
        exp_addr(32'h600, 32'd5);
        wait_addr("ar");
        m0_addr_valid = 1'b0;
        mem_beats(0, 2, 32'h61, 1'b0);
        mem_data_valid = 1'b1; mem_data = 32'h63;
        #1 check("ar_pre_m0_valid", 64'(m0_data_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_state", 64'(fsm_state), 64'd0);
        check("ar_m0_valid", 64'(m0_data_valid), 64'd0);
        check("ar_m0_data", 64'(m0_data), 64'd0);
        check("ar_resp_ready", 64'(mem_data_ready), 64'd0);
        check("ar_addr_valid", 64'(mem_addr_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_data_valid = 1'b0;
        m1_addr = 32'h700; m1_len = 32'd2; m1_addr_valid = 1'b1;
        exp_addr(32'h700, 32'd2);
        wait_addr("ar_m1");
        m1_addr_valid = 1'b0;
        mem_beats(1, 2, 32'h71, 1'b0);
        check("ar_idle_after", 64'(fsm_state), 64'd0);

        // Drain check
        repeat (2) @(posedge clk);
        #1;
        check("left_addr", 64'(exp_addr_q.size()), 64'd0);
        check("left_m0", 64'(exp_q0.size()), 64'd0);
        check("left_m1", 64'(exp_q1.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
